// File: rtl/prng_xoshiro_pkg.sv
// Shared constants and types for the xoshiro+ stream generator (xoshiro256+ at W=64, xoshiro128+ at W=32).
// Jump support is compiled in only when PRNG_XOSHIRO_JUMP_EN is defined.
package prng_xoshiro_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_JUMP = 1'b1
    } prng_fsm_e;

    localparam int unsigned SHIFT_A_64 = 17;
    localparam int unsigned SHIFT_B_64 = 45;
    localparam int unsigned SHIFT_A_32 = 9;
    localparam int unsigned SHIFT_B_32 = 11;

    localparam logic [255:0] RESET_SEED_64 = {64'd4, 64'd3, 64'd2, 64'd1};
    localparam logic [127:0] RESET_SEED_32 = {32'd4, 32'd3, 32'd2, 32'd1};

    // Word 0 sits in the LSBs so a flat bit index walks word 0 first, LSB first.
    localparam logic [255:0] JUMP256 = {64'h39abdc4529b1661c, 64'ha9582618e03fc9aa,
                                        64'hd5a61266f0c9392c, 64'h180ec6d33cfd0aba};
    localparam logic [127:0] JUMP128 = {32'h77f2db5b, 32'h6fa035c3,
                                        32'hf542d2d3, 32'h8764000b};

    function automatic int unsigned shift_a(input int unsigned w);
        return (w == 64) ? SHIFT_A_64 : SHIFT_A_32;
    endfunction

    function automatic int unsigned shift_b(input int unsigned w);
        return (w == 64) ? SHIFT_B_64 : SHIFT_B_32;
    endfunction

    function automatic logic [255:0] reset_seed(input int unsigned w);
        return (w == 64) ? RESET_SEED_64 : {128'd0, RESET_SEED_32};
    endfunction

    function automatic logic [255:0] jump_bits(input int unsigned w);
        return (w == 64) ? JUMP256 : {128'd0, JUMP128};
    endfunction

endpackage

// File: rtl/prng_xoshiro_stream_step.sv
// Combinational xoshiro+ next(): produces the next state and the s0+s3 result of the current state.
module prng_xoshiro_step
    import prng_xoshiro_pkg::*;
#(
    parameter int unsigned W = 64
) (
    input  logic [4*W-1:0] state,
    output logic [4*W-1:0] next_state,
    output logic [W-1:0]   result
);

    localparam int unsigned A = shift_a(W);
    localparam int unsigned B = shift_b(W);

    logic [W-1:0] s0, s1, s2, s3, t;

    always_comb begin
        s0 = state[0*W +: W];
        s1 = state[1*W +: W];
        s2 = state[2*W +: W];
        s3 = state[3*W +: W];
        result = s0 + s3;
        t  = s1 << A;
        s2 = s2 ^ s0;
        s3 = s3 ^ s1;
        s1 = s1 ^ s2;
        s0 = s0 ^ s3;
        s2 = s2 ^ t;
        s3 = (s3 << B) | (s3 >> (W - B));
        next_state = {s3, s2, s1, s0};
    end

endmodule

// File: rtl/prng_xoshiro_stream.sv
// xoshiro+ PRNG with a one-deep valid/ready output register, seed load and optional jump().
// Define PRNG_XOSHIRO_JUMP_EN to build the JUMP state, accumulator and jump constants.
module prng_xoshiro_stream
    import prng_xoshiro_pkg::*;
#(
    parameter int unsigned W = 64
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_cg,
    input  logic           i_seed_valid,
    input  logic [4*W-1:0] i_seed,
    input  logic           i_jump,
    output logic           o_busy,
    output logic [4*W-1:0] o_state,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [W-1:0]   o_result
);

    if (W != 64 && W != 32) begin : g_bad_w
        $error("prng_xoshiro_stream: W must be 64 or 32");
    end

    localparam logic [255:0]   SEED_FULL  = reset_seed(W);
    localparam logic [4*W-1:0] RESET_SEED = SEED_FULL[4*W-1:0];

    logic [4*W-1:0] state_q, state_d;
    logic [W-1:0]   result_q, result_d;
    logic           valid_q, valid_d;
    logic [4*W-1:0] step_next;
    logic [W-1:0]   step_result;

    prng_xoshiro_step #(.W(W)) u_step (
        .state      (state_q),
        .next_state (step_next),
        .result     (step_result)
    );

`ifdef PRNG_XOSHIRO_JUMP_EN
    localparam int unsigned    CNT_W     = $clog2(4 * W);
    localparam logic [255:0]   JUMP_FULL = jump_bits(W);
    localparam logic [4*W-1:0] JUMP_BITS = JUMP_FULL[4*W-1:0];

    prng_fsm_e      fsm_q, fsm_d;
    logic [4*W-1:0] acc_q, acc_d, acc_term;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign o_busy = (fsm_q == ST_JUMP);
`else
    logic unused_jump;
    assign unused_jump = i_jump;
    assign o_busy      = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        valid_d  = valid_q;
`ifdef PRNG_XOSHIRO_JUMP_EN
        fsm_d    = fsm_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        acc_term = acc_q ^ (JUMP_BITS[cnt_q] ? state_q : '0);
`endif
        if (i_seed_valid) begin
            state_d = (i_seed == '0) ? RESET_SEED : i_seed;
            valid_d = 1'b0;
`ifdef PRNG_XOSHIRO_JUMP_EN
            fsm_d   = ST_RUN;
        end else if (fsm_q == ST_JUMP) begin
            // Final cycle replaces the state with the accumulator, including this cycle's term.
            acc_d = acc_term;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(4 * W - 1)) begin
                state_d = acc_term;
                fsm_d   = ST_RUN;
            end else begin
                state_d = step_next;
            end
        end else if (i_jump) begin
            fsm_d   = ST_JUMP;
            valid_d = 1'b0;
            acc_d   = '0;
            cnt_d   = '0;
`endif
        end else if (!valid_q || i_ready) begin
            state_d  = step_next;
            result_d = step_result;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= RESET_SEED;
            result_q <= '0;
            valid_q  <= 1'b0;
`ifdef PRNG_XOSHIRO_JUMP_EN
            fsm_q    <= ST_RUN;
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else if (i_cg) begin
            state_q  <= state_d;
            result_q <= result_d;
            valid_q  <= valid_d;
`ifdef PRNG_XOSHIRO_JUMP_EN
            fsm_q    <= fsm_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign o_state  = state_q;
    assign o_result = result_q;
    assign o_valid  = valid_q;

endmodule

// File: tb/tb_prng_xoshiro_stream.sv
// Scoreboard bench for prng_xoshiro_stream (W=64 main instance, W=32 instance for the first results).
module tb_prng_xoshiro_stream;

    localparam logic [255:0] RST_SEED = {64'd4, 64'd3, 64'd2, 64'd1};
`ifdef PRNG_XOSHIRO_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n, cg, seed_valid, jump, ready;
    logic [255:0] seed;
    logic         busy, valid;
    logic [255:0] state;
    logic [63:0]  result;
    logic         busy32, valid32;
    logic [127:0] state32;
    logic [31:0]  result32;

    int tests = 0;
    int fails = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    prng_xoshiro_stream #(.W(64)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg), .i_seed_valid(seed_valid),
        .i_seed(seed), .i_jump(jump), .o_busy(busy), .o_state(state),
        .o_valid(valid), .i_ready(ready), .o_result(result)
    );

    prng_xoshiro_stream #(.W(32)) u_dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cg(1'b1), .i_seed_valid(1'b0),
        .i_seed(128'd0), .i_jump(1'b0), .o_busy(busy32), .o_state(state32),
        .o_valid(valid32), .i_ready(1'b1), .o_result(result32)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] model_next(input logic [255:0] s);
        logic [63:0] s0, s1, s2, s3, t;
        s0 = s[63:0]; s1 = s[127:64]; s2 = s[191:128]; s3 = s[255:192];
        t  = s1 << 17;
        s2 ^= s0; s3 ^= s1; s1 ^= s2; s0 ^= s3; s2 ^= t;
        s3 = (s3 << 45) | (s3 >> 19);
        return {s3, s2, s1, s0};
    endfunction

    function automatic logic [63:0] model_result(input logic [255:0] s);
        return s[63:0] + s[255:192];
    endfunction

    function automatic logic [255:0] model_jump(input logic [255:0] s_in);
        logic [63:0]  jc[4];
        logic [255:0] s, acc;
        jc[0] = 64'h180ec6d33cfd0aba; jc[1] = 64'hd5a61266f0c9392c;
        jc[2] = 64'ha9582618e03fc9aa; jc[3] = 64'h39abdc4529b1661c;
        s = s_in; acc = '0;
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < 64; b++) begin
                if (jc[i][b]) acc ^= s;
                s = model_next(s);
            end
        return acc;
    endfunction

    task automatic expect_stream(input logic [255:0] s_in, input int n);
        logic [255:0] s;
        s = s_in;
        sb_q.delete();
        for (int i = 0; i < n; i++) begin
            sb_q.push_back(model_result(s));
            s = model_next(s);
        end
    endtask

    // A result is consumed on the coming edge only if nothing of higher priority pre-empts it.
    always @(negedge clk) begin
        if (rst_n && cg && valid && ready && !seed_valid && !(JUMP_EN && jump)) begin
            if (sb_q.size() == 0) check("sb_extra", sb_q.size(), 1);
            else check("stream", result, sb_q.pop_front());
        end
    end

    task automatic drain(input int n, input bit pulse_jump);
        int guard;
        guard = 0;
        ready = 1'b1;
        while (sb_q.size() != 0 && guard < 2 * n + 20) begin
            @(posedge clk); #1;
            guard++;
            jump = pulse_jump && (guard == 3);
            if (pulse_jump) check("busy_idle", busy, 0);
        end
        jump  = 1'b0;
        check("drain", sb_q.size(), 0);
        ready = 1'b0;
    endtask

    task automatic seed_phase(input logic [255:0] sv, input logic [255:0] exp_s, input int n);
        @(posedge clk); #1;
        expect_stream(exp_s, n);
        seed = sv; seed_valid = 1'b1;
        @(posedge clk); #1;
        seed_valid = 1'b0;
        check("seed_state", state, exp_s);
        check("seed_valid_clr", valid, 0);
        drain(n, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] hold_s, rs, jumped;
        logic [63:0]  hold_r;
        int           bcnt;

        rst_n = 1'b0; cg = 1'b1; ready = 1'b1; seed_valid = 1'b0; seed = '0; jump = 1'b0;
        expect_stream(RST_SEED, 40);
        repeat (2) @(posedge clk); #1;
        check("rst_valid", valid, 0);
        check("rst_result", result, 0);
        check("rst_state", state, RST_SEED);
        check("rst_busy", busy, 0);
        check("rst_result32", result32, 0);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("first64", result, 64'h5);
        check("first_valid", valid, 1);
        check("first32", result32, 32'h5);
        check("first_valid32", valid32, 1);
        @(negedge clk);
        check("second64", result, 64'h0000C00000000007);
        check("second32", result32, 32'h3007);

        // Back-pressure: outputs frozen, then the stream resumes in order.
        repeat (8) @(posedge clk); #1;
        ready = 1'b0;
        @(negedge clk);
        hold_r = result; hold_s = state;
        repeat (5) begin
            @(negedge clk);
            check("stall_result", result, hold_r);
            check("stall_state", state, hold_s);
            check("stall_valid", valid, 1);
        end
        drain(40, 1'b0);

        @(posedge clk); #1;
        hold_s = state; cg = 1'b0; ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("cg_hold", state, hold_s);
        end
        @(posedge clk); #1;
        cg = 1'b1; ready = 1'b0;

        seed_phase({64'd4, 64'd3, 64'd2, 64'd1}, {64'd4, 64'd3, 64'd2, 64'd1}, 1000);
        seed_phase('0, RST_SEED, 20);
        for (int k = 0; k < 8; k++) rs[k*32 +: 32] = $urandom;
        seed_phase(rs, rs, 50);

`ifdef PRNG_XOSHIRO_JUMP_EN
        @(posedge clk); #1;
        rst_n = 1'b0; sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1; jump = 1'b1;
        @(posedge clk); #1;
        jump = 1'b0;
        bcnt = 0;
        for (int g = 0; g < 600; g++) begin
            @(negedge clk);
            if (!busy) break;
            bcnt++;
        end
        check("jump_busy_cycles", bcnt, 256);
        jumped = model_jump(RST_SEED);
        check("jump_state", state, jumped);
        check("jump_valid", valid, 0);
        expect_stream(jumped, 30);
        drain(30, 1'b0);

        @(posedge clk); #1;
        jump = 1'b1;
        @(posedge clk); #1;
        jump = 1'b0;
        repeat (50) @(posedge clk); #1;
        check("busy_mid", busy, 1);
        rs = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978, 64'h1122334455667788};
        expect_stream(rs, 10);
        seed = rs; seed_valid = 1'b1;
        @(posedge clk); #1;
        seed_valid = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_state", state, rs);
        drain(10, 1'b0);
`else
        rs = {64'h1111, 64'h2222, 64'h3333, 64'h4444};
        @(posedge clk); #1;
        expect_stream(rs, 30);
        seed = rs; seed_valid = 1'b1;
        @(posedge clk); #1;
        seed_valid = 1'b0;
        drain(30, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prng_xoshiro_stream.md
PRNG_XOSHIRO_STREAM -- requirements
Module: prng_xoshiro_stream

Interface
REQ-001 SHALL have parameter W, default 64: word width. 64 selects xoshiro256+ (shifts 17/45); 32 selects xoshiro128+ (shifts 9/11); any other value is an elaboration error.
REQ-002 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port i_cg  input  1  clock-enable; when low, all state holds.
REQ-005 SHALL have port i_seed_valid  input  1  load seed this cycle.
REQ-006 SHALL have port i_seed  input  4*W  seed {s3,s2,s1,s0}, s0 in LSBs.
REQ-007 SHALL have port i_jump  input  1  request jump() (2^128 or 2^64 steps ahead).
REQ-008 SHALL have port o_busy  output  1  jump in progress.
REQ-009 SHALL have port o_state  output  4*W  current state register, packed as i_seed.
REQ-010 SHALL have port o_valid  output  1  o_result holds an unconsumed result.
REQ-011 SHALL have port i_ready  input  1  consumer accepts o_result.
REQ-012 SHALL have port o_result  output  W  registered s0+s3, modulo 2^W.

Function
REQ-013 SHALL update the state once per next() per the xoshiro+ algorithm: result=s0+s3; t=s1<<A; s2^=s0; s3^=s1; s1^=s2; s0^=s3; s2^=t; s3=rotl(s3,B).
REQ-014 SHALL use a one-deep output register: step and load when (!o_valid || i_ready) in RUN, with no seed and no jump; otherwise hold state and o_result.
REQ-015 SHALL sustain one result per cycle while i_ready is held high; o_result and o_valid SHALL remain stable while o_valid && !i_ready.
REQ-016 SHALL use an FSM with states RUN and JUMP.
REQ-017 RUN->JUMP on i_jump when not seeding: clear o_valid, zero the accumulator, raise o_busy.
REQ-018 In JUMP, SHALL run 4*W cycles over jump-constant bits (word 0 first, LSB first): if the bit is set, accumulator ^= state; then step the state.
REQ-019 On the last JUMP cycle, state SHALL be set to accumulator (including that cycle's term), the FSM SHALL return to RUN, and o_busy SHALL fall; the first o_valid SHALL follow on the next edge.
REQ-020 i_jump SHALL be ignored in JUMP.
REQ-021 i_ready SHALL be ignored while o_valid is low.
REQ-022 i_seed_valid SHALL win over every other event: state<=i_seed, o_valid<=0, FSM->RUN (an active jump is aborted), and the refill follows next cycle.
REQ-023 An all-zero i_seed SHALL load RESET_SEED instead.

Reset
REQ-024 Reset SHALL set state=RESET_SEED, FSM=RUN, o_valid=0, o_busy=0, o_result=0, accumulator=0.
REQ-025 The first rising edge after i_rst_n rises (with i_cg high) SHALL load o_result=s0+s3 of RESET_SEED and set o_valid=1.
REQ-026 Reset asserted during JUMP SHALL abandon the jump; no partial state is retained.

Configuration
REQ-027 Macro PRNG_XOSHIRO_JUMP_EN defined: JUMP state, accumulator and jump constants are present as specified.
REQ-028 Macro PRNG_XOSHIRO_JUMP_EN undefined: no accumulator or JUMP state; i_jump is ignored; o_busy is tied 0; all other behaviour is identical.

Structure
REQ-029 Package prng_xoshiro_pkg SHALL hold:
- RESET_SEED per W: s0=1, s1=2, s2=3, s3=4.
- Shift constants per W: 17/45 for W=64, 9/11 for W=32.
- JUMP256 constants: 0x180ec6d33cfd0aba, 0xd5a61266f0c9392c, 0xa9582618e03fc9aa, 0x39abdc4529b1661c.
- JUMP128 constants: 0x8764000b, 0xf542d2d3, 0x6fa035c3, 0x77f2db5b.
- FSM state enum.
REQ-030 The combinational next() SHALL be a sub-module prng_xoshiro_step (parameter W; in: state; out: next state, result), shared by the RUN and JUMP paths.

Verification
REQ-031 W=64, reset release, i_ready=1 -> o_result 0x5 then 0x0000C00000000007 on consecutive cycles.
REQ-032 W=32, same stimulus -> o_result 0x5 then 0x3007.
REQ-033 i_ready=0 for 5 cycles with o_valid=1 -> o_result and o_state constant; release -> sequence resumes without skipping a value.
REQ-034 Seed {4,3,2,1} (s0=1) -> next o_result 5 and matches the C model for 1000 results; all-zero seed -> same stream as after reset.
REQ-035 Jump from RESET_SEED (W=64) -> o_busy high exactly 256 cycles; o_state equals C jump() output; seed pulse mid-jump -> o_busy falls next cycle and state equals the seed.
REQ-036 Build without PRNG_XOSHIRO_JUMP_EN, pulse i_jump -> o_busy stays 0 and the stream is unaffected.
